// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out frame serializer: captures N entries on load and streams
// one OUT_W-bit field per accepted beat over valid/ready, with zero-skip and frame count.
module piso_frame_serializer #(
    parameter int unsigned N         = 16,
    parameter int unsigned ENTRY_W   = 25,
    parameter int unsigned OUT_W     = 9,
    parameter int unsigned MSB_ALIGN = 1,
    parameter int unsigned SKIP_ZERO = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [N*ENTRY_W-1:0] data_in,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overrun,
    output logic [CNT_W-1:0]     frame_count
);

    localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LSB_OFF = (MSB_ALIGN != 0) ? (ENTRY_W - OUT_W) : 0;
    localparam logic [N-1:0] ONE_N  = N'(1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                  state_q, state_d;
    logic [N-1:0][OUT_W-1:0] fields_q, fields_d;
    logic [N-1:0]            mask_q, mask_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    overrun_q, overrun_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;

    logic [N-1:0][OUT_W-1:0] ext;
    logic [N-1:0]            ld_mask;
    logic [IDX_W-1:0]        sel;
    logic                    xfer;
    logic                    unused_bits;

    // Entry bits outside the extracted field are intentionally ignored.
    assign unused_bits = ^data_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fields_q    <= '0;
            mask_q      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fields_q    <= fields_d;
            mask_q      <= mask_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fields_d    = fields_q;
        mask_d      = mask_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        out_data_d  = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        sel         = '0;
        ext         = '0;
        ld_mask     = '0;
        xfer        = out_valid_q & out_ready;

        for (int i = 0; i < N; i++) begin
            ext[i]     = data_in[i*ENTRY_W + LSB_OFF +: OUT_W];
            ld_mask[i] = (SKIP_ZERO != 0) ? |ext[i] : 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    fields_d = ext;
                    mask_d   = ld_mask;
                end
            end
            EMIT: begin
                if (xfer) begin
                    mask_d = mask_q & (mask_q - ONE_N);
                    if (out_last_q) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                // A load is only taken when it coincides with the final transfer.
                if (load) begin
                    if (xfer && out_last_q) begin
                        fields_d = ext;
                        mask_d   = ld_mask;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        state_d = (|mask_d) ? EMIT : IDLE;

        for (int i = N - 1; i >= 0; i--) begin
            if (mask_d[i]) begin
                sel = IDX_W'(i);
            end
        end

        if (|mask_d) begin
            out_data_d  = fields_d[sel];
            out_valid_d = 1'b1;
            out_last_d  = ~|(mask_d & (mask_d - ONE_N));
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = out_valid_q;
    assign overrun     = overrun_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_piso_frame_serializer.sv
// Directed bench for piso_frame_serializer: default, zero-skip and small-generic instances.
module tb_piso_frame_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: defaults
    logic         load_a, ready_a, valid_a, last_a, busy_a, ovr_a;
    logic [399:0] din_a;
    logic [8:0]   data_a;
    logic [15:0]  cnt_a;

    // Instance B: zero skipping
    logic         load_b, ready_b, valid_b, last_b, busy_b, ovr_b;
    logic [399:0] din_b;
    logic [8:0]   data_b;
    logic [15:0]  cnt_b;

    // Instance C: small generics, LSB aligned
    logic         load_c, ready_c, valid_c, last_c, busy_c, ovr_c;
    logic [47:0]  din_c;
    logic [4:0]   data_c;
    logic [1:0]   cnt_c;

    piso_frame_serializer u_a (
        .clk(clk), .reset(rst), .load(load_a), .data_in(din_a),
        .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a), .out_last(last_a),
        .busy(busy_a), .overrun(ovr_a), .frame_count(cnt_a)
    );

    piso_frame_serializer #(.SKIP_ZERO(1)) u_b (
        .clk(clk), .reset(rst), .load(load_b), .data_in(din_b),
        .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b), .out_last(last_b),
        .busy(busy_b), .overrun(ovr_b), .frame_count(cnt_b)
    );

    piso_frame_serializer #(.N(4), .ENTRY_W(12), .OUT_W(5), .MSB_ALIGN(0), .CNT_W(2)) u_c (
        .clk(clk), .reset(rst), .load(load_c), .data_in(din_c),
        .out_data(data_c), .out_valid(valid_c), .out_ready(ready_c), .out_last(last_c),
        .busy(busy_c), .overrun(ovr_c), .frame_count(cnt_c)
    );

    function automatic logic [399:0] pat_a(input int base);
        logic [399:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i*25 +: 25] = {9'(base + i), 16'h0000};
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
        ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
        din_a = '0; din_b = '0; din_c = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({data_a, valid_a, last_a, busy_a, ovr_a, cnt_a} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_a got %h required 0", {data_a, valid_a, last_a, busy_a, ovr_a, cnt_a});
        end
        n_checks++;
        if ({data_b, valid_b, last_b, busy_b, ovr_b, cnt_b} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_b got %h required 0", {data_b, valid_b, last_b, busy_b, ovr_b, cnt_b});
        end
        n_checks++;
        if ({data_c, valid_c, last_c, busy_c, ovr_c, cnt_c} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_c got %h required 0", {data_c, valid_c, last_c, busy_c, ovr_c, cnt_c});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [11:0] exp;
        din_a = pat_a(100); ready_a = 1'b1; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            exp = {1'b1, 1'b1, 9'(100 + k), (k == 15)};
            n_checks++;
            if ({valid_a, busy_a, data_a, last_a} !== exp) begin
                n_fail++;
                $display("FAIL basic_word k=%0d got %h required %h", k, {valid_a, busy_a, data_a, last_a}, exp);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({valid_a, busy_a, data_a, cnt_a, ovr_a} !== {2'b00, 9'd0, 16'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_end got valid=%0d data=%0d cnt=%0d ovr=%0d required 0/0/1/0", valid_a, data_a, cnt_a, ovr_a);
        end
    endtask

    task automatic test_backpressure();
        int idx   = 0;
        int stall = 0;
        din_a = pat_a(100); ready_a = 1'b1; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        for (int cyc = 0; cyc < 40 && idx < 16; cyc++) begin
            n_checks++;
            if ({valid_a, data_a, last_a} !== {1'b1, 9'(100 + idx), (idx == 15)}) begin
                n_fail++;
                $display("FAIL bp_word idx=%0d got v=%0d d=%0d l=%0d required 1/%0d/%0d", idx, valid_a, data_a, last_a, 100 + idx, idx == 15);
            end
            if (idx == 4 && stall < 3) begin
                ready_a = 1'b0;
                stall++;
            end else begin
                ready_a = 1'b1;
                idx++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (idx != 16 || valid_a !== 1'b0 || cnt_a !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_end got idx=%0d valid=%0d cnt=%0d required 16/0/2", idx, valid_a, cnt_a);
        end
    endtask

    task automatic test_overrun_b2b();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        din_a = pat_a(100); ready_a = 1'b1; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if ({valid_a, data_a, last_a} !== {1'b1, 9'(100 + k), (k == 15)}) begin
                n_fail++;
                $display("FAIL ovr_frame1 k=%0d got d=%0d l=%0d required %0d/%0d", k, data_a, last_a, 100 + k, k == 15);
            end
            if (k == 6) begin
                din_a  = pat_a(200);
                load_a = 1'b1;
            end else if (k == 7) begin
                load_a = 1'b0;
                n_checks++;
                if (ovr_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovr_flag got %0d required 1", ovr_a);
                end
            end else if (k == 15) begin
                din_a  = pat_a(300);
                load_a = 1'b1;
            end
            @(negedge clk);
        end
        load_a = 1'b0;
        din_a  = pat_a(400);
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if ({valid_a, data_a, last_a} !== {1'b1, 9'(300 + k), (k == 15)}) begin
                n_fail++;
                $display("FAIL b2b_frame2 k=%0d got v=%0d d=%0d l=%0d required 1/%0d/%0d", k, valid_a, data_a, last_a, 300 + k, k == 15);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({valid_a, cnt_a, ovr_a} !== {1'b0, 16'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_end got valid=%0d cnt=%0d ovr=%0d required 0/2/1", valid_a, cnt_a, ovr_a);
        end
    endtask

    task automatic test_reset_mid();
        din_a = pat_a(100); ready_a = 1'b1; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({valid_a, data_a} !== {1'b1, 9'(100 + k)}) begin
                n_fail++;
                $display("FAIL rmid_pre k=%0d got d=%0d required %0d", k, data_a, 100 + k);
            end
            if (k == 4) rst = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if ({data_a, valid_a, last_a, busy_a, ovr_a, cnt_a} !== 29'd0) begin
            n_fail++;
            $display("FAIL rmid_zero got %h required 0", {data_a, valid_a, last_a, busy_a, ovr_a, cnt_a});
        end
        rst = 1'b0;
        load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if ({valid_a, data_a, last_a} !== {1'b1, 9'(100 + k), (k == 15)}) begin
                n_fail++;
                $display("FAIL rmid_restart k=%0d got v=%0d d=%0d required 1/%0d", k, valid_a, data_a, 100 + k);
            end
            @(negedge clk);
        end
        n_checks++;
        if (cnt_a !== 16'd1) begin
            n_fail++;
            $display("FAIL rmid_count got %0d required 1", cnt_a);
        end
    endtask

    task automatic test_skip_zero();
        int ev[3];
        ev = '{33, 200, 511};
        for (int i = 0; i < 16; i++) din_b[i*25 +: 25] = {9'd0, 16'hFFFF};
        din_b[2*25 +: 25]  = {9'd33, 16'h0000};
        din_b[7*25 +: 25]  = {9'd200, 16'h0000};
        din_b[15*25 +: 25] = {9'd511, 16'h0000};
        ready_b = 1'b1; load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({valid_b, data_b, last_b} !== {1'b1, 9'(ev[k]), (k == 2)}) begin
                n_fail++;
                $display("FAIL skip_word k=%0d got v=%0d d=%0d l=%0d required 1/%0d/%0d", k, valid_b, data_b, last_b, ev[k], k == 2);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({valid_b, cnt_b} !== {1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL skip_end got valid=%0d cnt=%0d required 0/1", valid_b, cnt_b);
        end
        for (int i = 0; i < 16; i++) din_b[i*25 +: 25] = {9'd0, 16'hA5A5};
        load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({valid_b, busy_b, data_b} !== 11'd0) begin
                n_fail++;
                $display("FAIL skip_allzero k=%0d got v=%0d b=%0d d=%0d required 0/0/0", k, valid_b, busy_b, data_b);
            end
            @(negedge clk);
        end
        n_checks++;
        if (cnt_b !== 16'd1) begin
            n_fail++;
            $display("FAIL skip_allzero_cnt got %0d required 1", cnt_b);
        end
    endtask

    task automatic test_generics();
        int ev[4];
        logic [1:0] ecnt;
        ev = '{31, 3, 16, 0};
        din_c = {12'h000, 12'h010, 12'h003, 12'h01F};
        ready_c = 1'b1;
        for (int f = 0; f < 4; f++) begin
            load_c = 1'b1;
            @(negedge clk);
            load_c = 1'b0;
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if ({valid_c, data_c, last_c} !== {1'b1, 5'(ev[k]), (k == 3)}) begin
                    n_fail++;
                    $display("FAIL gen_word f=%0d k=%0d got v=%0d d=%0d l=%0d required 1/%0d/%0d", f, k, valid_c, data_c, last_c, ev[k], k == 3);
                end
                @(negedge clk);
            end
            ecnt = 2'(f + 1);
            n_checks++;
            if ({valid_c, cnt_c} !== {1'b0, ecnt}) begin
                n_fail++;
                $display("FAIL gen_count f=%0d got valid=%0d cnt=%0d required 0/%0d", f, valid_c, cnt_c, ecnt);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun_b2b();
        test_reset_mid();
        test_skip_zero();
        test_generics();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_frame_serializer.md
# piso_frame_serializer

Parametrised parallel-in/serial-out frame serializer that replaces the fixed 16-entry PISO between the spectral-peak detector and the dual-clock FIFO feeding the SPI link. On `load` it captures N peak entries and emits one OUT_W-bit field per accepted beat over a valid/ready handshake, so it can respect FIFO-full backpressure. It adds optional zero-entry skipping, a last-word marker, a frame counter and a sticky overrun flag.

## Interface
- `N`, 16: entries per frame (2..64).
- `ENTRY_W`, 25: width of one input entry.
- `OUT_W`, 9: width of the emitted field (1..ENTRY_W).
- `MSB_ALIGN`, 1: 1 = field is entry[ENTRY_W-1 -: OUT_W]; 0 = field is entry[OUT_W-1:0].
- `SKIP_ZERO`, 0: 1 = entries whose extracted field is zero are not emitted.
- `CNT_W`, 16: frame counter width.
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `load`  in  1  capture request for a frame, single-cycle pulse.
- `data_in`  in  N*ENTRY_W  entry i at [i*ENTRY_W +: ENTRY_W]; entry 0 emitted first.
- `out_data`  out  OUT_W  current field.
- `out_valid`  out  1  out_data holds a word.
- `out_ready`  in  1  sink accepts; tie to ~wfull of the FIFO.
- `out_last`  out  1  current word is the final one of the frame.
- `busy`  out  1  frame in progress (equals out_valid).
- `overrun`  out  1  sticky: a load was dropped.
- `frame_count`  out  CNT_W  completed frames, modulo 2^CNT_W.

Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- States: IDLE, EMIT.
- IDLE + load: all N fields are extracted and registered together with an N-bit pending mask. The mask is all ones, or, with SKIP_ZERO=1, one bit per nonzero field. If the mask is nonzero, go to EMIT. If the mask is zero (every field zero under SKIP_ZERO), stay in IDLE, emit nothing, and leave frame_count unchanged.
- EMIT: out_data = field at the lowest set mask bit. out_last = 1 iff exactly one mask bit is set.
- Transfer = out_valid & out_ready. On a transfer, clear the current mask bit. After the transfer with out_last, increment frame_count and return to IDLE.
- While out_valid & ~out_ready, out_data and out_last stay stable. No word is dropped or duplicated.
- Skipped entries cost no cycles. The next nonzero entry is presented on the cycle after the previous transfer.
- load while in EMIT and not on the final-transfer cycle: ignored, overrun set to 1. overrun clears only on reset.
- load on the same cycle as the final transfer (out_last & out_ready): accepted as a back-to-back frame, no overrun. The new frame's first word is valid on the next cycle.
- data_in is sampled only on the accepting load cycle. Later changes have no effect.

## Timing
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, overrun=0, frame_count=0, mask=0, state IDLE.
- Reset asserted mid-frame: the frame is aborted and all of the above are restored on the next edge. frame_count is not incremented.
- Load latency: load at edge t gives out_valid=1 with the first word after edge t, visible in cycle t+1.
- Throughput: one word per cycle while out_ready=1. A K-word frame with ready held high occupies cycles t+1..t+K, with out_last in cycle t+K.
- In IDLE, out_data is 0.
- frame_count wraps from 2^CNT_W-1 to 0.

## Test plan
- Defaults, entries i = {9'd(100+i), 16'h0}, ready=1, one load: 100..115 emitted in consecutive cycles starting one cycle after load. out_last only on 115. frame_count=1, overrun=0.
- Backpressure: same frame, out_ready low for 3 cycles after the 5th word is presented: word 104 is held stable for 3 cycles, then the sequence resumes. 16 words total with no gaps or duplicates.
- SKIP_ZERO=1, fields nonzero only at entries 2, 7, 15 (values 33, 200, 511): exactly 33, 200, 511 are emitted on consecutive cycles, with out_last on 511. An all-zero frame gives no out_valid and frame_count unchanged.
- Overrun and back-to-back:
  - A load pulse during word 6: ignored, overrun=1, the current frame completes unchanged.
  - A load on the out_last-transfer cycle: the next frame's word 0 is valid the following cycle, frame_count=2 after the second frame.
- Reset mid-frame after 4 words: all outputs zero next cycle. A subsequent load restarts from entry 0.
- Generics N=4, ENTRY_W=12, OUT_W=5, MSB_ALIGN=0, CNT_W=2, entries 0x01F, 0x003, 0x010, 0x000: emits 31, 3, 16, 0. After 4 frames, frame_count wraps to 0.
